// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider, signed or unsigned.
//
// Ports:
//   clk_i           sole clock, rising edge
//   rst_ni          asynchronous active-low reset
//   start_i         divide request, sampled only in IDLE
//   signed_div_i    1 = two's-complement divide, 0 = unsigned; sampled with start_i
//   annul_i         flush; aborts any operation in progress
//   a_i, b_i        dividend / divisor, sampled with start_i
//   busy_o          high while in DIV or DONE
//   done_o          one-cycle pulse, results valid
//   quot_o, rem_o   quotient (to LO) and remainder (to HI)
//   div_by_zero_o   high alongside done_o when the divisor was zero
//
// Results are written only on the edge that enters DONE and hold until the next
// DONE entry. All outputs come straight from registers.
module div_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNTW  = 6
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             signed_div_i,
   input  logic             annul_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o,
   output logic             div_by_zero_o
);

   typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] prem_q, prem_d;   // partial remainder
   logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifts out MSB-first, quotient shifts in
   logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   r_sh, diff;
   logic             fits;
   logic [WIDTH-1:0] r_next, q_next;

   assign a_neg = signed_div_i & a_i[WIDTH-1];
   assign b_neg = signed_div_i & b_i[WIDTH-1];
   // Most-negative value maps to itself, which is its correct unsigned magnitude.
   assign a_mag = a_neg ? -a_i : a_i;
   assign b_mag = b_neg ? -b_i : b_i;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   assign r_sh   = {prem_q, dvd_q[WIDTH-1]};
   assign diff   = r_sh - {1'b0, dvs_q};
   assign fits   = ~diff[WIDTH];
   assign r_next = fits ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
   assign q_next = {dvd_q[WIDTH-2:0], fits};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         StIdle: begin
            if (start_i && !annul_i) begin
               if (b_i == '0) begin
                  state_d = StDone;
                  quot_d  = '1;
                  rem_d   = a_i;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = StDiv;
                  cnt_d   = '0;
                  prem_d  = '0;
                  dvd_d   = a_mag;
                  dvs_d   = b_mag;
                  negq_d  = a_neg ^ b_neg;
                  negr_d  = a_neg;
               end
            end
         end
         StDiv: begin
            if (annul_i) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               prem_d = r_next;
               dvd_d  = q_next;
               cnt_d  = cnt_q + CNTW'(1);
               if (cnt_q == CNTW'(WIDTH - 1)) begin
                  state_d = StDone;
                  quot_d  = negq_q ? -q_next : q_next;
                  rem_d   = negr_q ? -r_next : r_next;
                  dbz_d   = 1'b0;
               end
            end
         end
         StDone: begin
            // Results are already registered; annul has nothing left to abort.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         prem_q  <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy_o        = (state_q != StIdle);
   assign done_o        = (state_q == StDone);
   assign quot_o        = quot_q;
   assign rem_o         = rem_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, sdiv, annul;
   logic [31:0] a, b;
   logic        busy, done, dbz;
   logic [31:0] quot, rem;

   logic        start8, sdiv8, annul8;
   logic [7:0]  a8, b8;
   logic        busy8, done8, dbz8;
   logic [7:0]  quot8, rem8;

   int checks   = 0;
   int failures = 0;
   int lat, bcnt, dones;

   always #5 clk = ~clk;

   div_unit #(.WIDTH(32), .CNTW(6)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .signed_div_i(sdiv), .annul_i(annul),
      .a_i(a), .b_i(b), .busy_o(busy), .done_o(done), .quot_o(quot), .rem_o(rem),
      .div_by_zero_o(dbz)
   );

   div_unit #(.WIDTH(8), .CNTW(4)) u_dut8 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .signed_div_i(sdiv8), .annul_i(annul8),
      .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8), .quot_o(quot8), .rem_o(rem8),
      .div_by_zero_o(dbz8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Launch one operation and wait (bounded) for done; lat = -1 on timeout.
   task automatic run32(input logic s, input logic [31:0] av, input logic [31:0] bv,
                        output int l, output int bc);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; sdiv = s; a = av; b = bv;
      l = -1; bc = 0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) bc++;
         if (done) begin
            l = n;
            break;
         end
      end
   endtask

   task automatic run8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                       output int l);
      @(negedge clk);
      @(negedge clk);
      start8 = 1'b1; sdiv8 = s; a8 = av; b8 = bv;
      l = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         start8 = 1'b0;
         if (done8) begin
            l = n;
            break;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; sdiv = 1'b0; annul = 1'b0; a = '0; b = '0;
      start8 = 1'b0; sdiv8 = 1'b0; annul8 = 1'b0; a8 = '0; b8 = '0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_quot", quot, 0);
      check("rst_rem", rem, 0);
      check("rst_dbz", dbz, 0);
      check("rst_quot8", quot8, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Unsigned 100/7
      run32(1'b0, 32'd100, 32'd7, lat, bcnt);
      check("u_lat", lat, 33);
      check("u_busy_cycles", bcnt, 33);
      check("u_quot", quot, 14);
      check("u_rem", rem, 2);
      check("u_dbz", dbz, 0);
      @(negedge clk);
      check("u_done_single", done, 0);

      // Signed -7/2 and the same bits as unsigned
      run32(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
      check("s_quot", quot, 32'hFFFF_FFFD);
      check("s_rem", rem, 32'hFFFF_FFFF);
      run32(1'b0, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
      check("us_quot", quot, 32'h7FFF_FFFC);
      check("us_rem", rem, 1);
      // Signed 7/-2: remainder follows dividend sign
      run32(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
      check("s2_quot", quot, 32'hFFFF_FFFD);
      check("s2_rem", rem, 1);
      // Signed min / -1
      run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
      check("min_quot", quot, 32'h8000_0000);
      check("min_rem", rem, 0);
      check("min_dbz", dbz, 0);

      // Zero divisor
      run32(1'b0, 32'h1234, 32'd0, lat, bcnt);
      check("z_lat", lat, 1);
      check("z_quot", quot, 32'hFFFF_FFFF);
      check("z_rem", rem, 32'h1234);
      check("z_dbz", dbz, 1);

      // Annul at DIV edge 10
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; sdiv = 1'b0; a = 32'd100; b = 32'd7;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("an_busy_before", busy, 1);
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0;
      check("an_busy", busy, 0);
      check("an_done", done, 0);
      check("an_quot_hold", quot, 32'hFFFF_FFFF);
      check("an_rem_hold", rem, 32'h1234);
      check("an_dbz_hold", dbz, 1);
      dones = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("an_no_done", dones, 0);
      run32(1'b0, 32'd9, 32'd3, lat, bcnt);
      check("an_new_lat", lat, 33);
      check("an_new_quot", quot, 3);
      check("an_new_rem", rem, 0);
      check("an_new_dbz", dbz, 0);

      // Annul and start together in IDLE: start dropped
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; annul = 1'b1; a = 32'd50; b = 32'd5;
      @(negedge clk);
      start = 1'b0; annul = 1'b0;
      check("as_busy", busy, 0);
      check("as_quot_hold", quot, 3);

      // Start held through an entire operation
      @(negedge clk);
      start = 1'b1; sdiv = 1'b0; a = 32'd100; b = 32'd7;
      dones = 0; lat = -1;
      for (int n = 1; n <= 80; n++) begin
         @(negedge clk);
         if (n == 34) start = 1'b0;
         if (done) begin
            dones++;
            if (lat < 0) lat = n;
         end
      end
      check("hold_dones", dones, 1);
      check("hold_lat", lat, 33);
      check("hold_quot", quot, 14);

      // Reset mid-DIV
      @(negedge clk);
      start = 1'b1; a = 32'd9; b = 32'd3;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      check("mr_busy", busy, 0);
      check("mr_done", done, 0);
      check("mr_quot", quot, 0);
      check("mr_rem", rem, 0);
      check("mr_dbz", dbz, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("mr_no_done", dones, 0);
      run32(1'b0, 32'd100, 32'd7, lat, bcnt);
      check("mr_restart_lat", lat, 33);
      check("mr_restart_quot", quot, 14);

      // 8-bit instance
      run8(1'b0, 8'd255, 8'd16, lat);
      check("w8_lat", lat, 9);
      check("w8_quot", quot8, 15);
      check("w8_rem", rem8, 15);
      check("w8_dbz", dbz8, 0);
      run8(1'b1, 8'h9C, 8'd7, lat);   // -100 / 7
      check("w8s_quot", quot8, 8'hF2);
      check("w8s_rem", rem8, 8'hFE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
